// File: rtl/dma_priority_arbiter_pkg.sv
// Shared types and constants for the DMA channel priority arbiter.
// The priority pick is a rotate / find-first / un-rotate function.
package dma_priority_arbiter_pkg;

  localparam int NCH = 4;

  localparam int CMD_DISABLE   = 2;
  localparam int CMD_ROTATE    = 4;
  localparam int CMD_DREQ_LOW  = 6;
  localparam int CMD_DACK_HIGH = 7;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_REQ   = 2'd1,
    ARB_GRANT = 2'd2
  } arb_state_t;

  // Only meaningful when pend is non-zero; the caller guards on that.
  function automatic logic [1:0] pick_winner(input logic [3:0] pend, input logic [1:0] ptr);
    logic [7:0] dbl;
    logic [3:0] rot;
    logic [1:0] off;
    dbl = {pend, pend};
    rot = dbl[ptr +: 4];
    off = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (rot[i]) off = 2'(i);
    end
    return off + ptr;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] ch);
    return 4'b0001 << ch;
  endfunction

endpackage

// File: rtl/dma_req_sync.sv
// Two-flop synchronizer bringing the raw DREQ pins into the CLK domain.
module dma_req_sync #(
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic [W-1:0] i_async,
  output logic [W-1:0] o_sync
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/dma_priority_arbiter.sv
// 8237A-style channel arbiter: conditions DREQ, picks a channel under fixed or
// rotating priority, and holds the grant until the timing FSM ends service.
module dma_priority_arbiter #(
  parameter int NCH = dma_priority_arbiter_pkg::NCH
) (
  input  logic           CLK,
  input  logic           RESET_N,
  input  logic [NCH-1:0] DREQ,
  input  logic [7:0]     commandReg,
  input  logic [NCH-1:0] maskReg,
  input  logic [NCH-1:0] requestReg,
  input  logic           idleCycle,
  input  logic           activeCycle,
  input  logic           validDack,
  input  logic           serviceDone,
  output logic [NCH-1:0] VALID_DREQ,
  output logic [1:0]     grantCh,
  output logic           grantValid,
  output logic [NCH-1:0] DACK,
  output logic [1:0]     priorityPtr
);

  import dma_priority_arbiter_pkg::*;

  logic [NCH-1:0] w_syncDreq;
  logic [NCH-1:0] w_sreq;
  logic [NCH-1:0] w_pend;
  logic [1:0]     w_effPtr;
  logic [1:0]     w_pick;
  logic           w_disable;
  logic           w_rotate;
  logic           w_unusedCmd;

  arb_state_t     r_state, w_stateNext;
  logic [1:0]     r_winner, w_winnerNext;
  logic [1:0]     r_grantCh, w_grantChNext;
  logic [1:0]     r_ptr, w_ptrNext;
  logic           r_grantValid, w_grantValidNext;
  logic [NCH-1:0] r_validDreq, w_validDreqNext;

  dma_req_sync #(.W(NCH)) u_sync (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .i_async (DREQ),
    .o_sync  (w_syncDreq)
  );

  assign w_disable   = commandReg[CMD_DISABLE];
  assign w_rotate    = commandReg[CMD_ROTATE];
  assign w_unusedCmd = ^{commandReg[5], commandReg[3], commandReg[1:0]};

  assign w_sreq   = w_syncDreq ^ {NCH{commandReg[CMD_DREQ_LOW]}};
  assign w_pend   = (w_sreq & ~maskReg) | requestReg;
  assign w_effPtr = w_rotate ? r_ptr : 2'd0;
  assign w_pick   = pick_winner(w_pend, w_effPtr);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state      <= ARB_IDLE;
      r_winner     <= 2'd0;
      r_grantCh    <= 2'd0;
      r_ptr        <= 2'd0;
      r_grantValid <= 1'b0;
      r_validDreq  <= '0;
    end else begin
      r_state      <= w_stateNext;
      r_winner     <= w_winnerNext;
      r_grantCh    <= w_grantChNext;
      r_ptr        <= w_ptrNext;
      r_grantValid <= w_grantValidNext;
      r_validDreq  <= w_validDreqNext;
    end
  end

  // A committed grant ignores disable; a pending offer yields to activeCycle first.
  always_comb begin
    w_stateNext      = r_state;
    w_winnerNext     = r_winner;
    w_grantChNext    = r_grantCh;
    w_grantValidNext = r_grantValid;
    w_validDreqNext  = r_validDreq;
    w_ptrNext        = w_rotate ? r_ptr : 2'd0;
    case (r_state)
      ARB_IDLE: begin
        w_validDreqNext = '0;
        if (idleCycle && !w_disable && (w_pend != '0)) begin
          w_winnerNext    = w_pick;
          w_validDreqNext = onehot(w_pick);
          w_stateNext     = ARB_REQ;
        end
      end
      ARB_REQ: begin
        if (activeCycle) begin
          w_grantChNext    = r_winner;
          w_grantValidNext = 1'b1;
          w_stateNext      = ARB_GRANT;
        end else if (!w_pend[r_winner] || w_disable) begin
          w_validDreqNext = '0;
          w_stateNext     = ARB_IDLE;
        end
      end
      ARB_GRANT: begin
        if (serviceDone) begin
          w_grantValidNext = 1'b0;
          w_validDreqNext  = '0;
          if (w_rotate) w_ptrNext = r_grantCh + 2'd1;
          w_stateNext = ARB_IDLE;
        end
      end
      default: begin
        w_grantValidNext = 1'b0;
        w_validDreqNext  = '0;
        w_stateNext      = ARB_IDLE;
      end
    endcase
  end

  assign VALID_DREQ  = r_validDreq;
  assign grantCh     = r_grantCh;
  assign grantValid  = r_grantValid;
  assign priorityPtr = r_ptr;
  assign DACK = ((r_grantValid && validDack) ? onehot(r_grantCh) : '0)
                ^ {NCH{~commandReg[CMD_DACK_HIGH]}};

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed scenarios plus randomized traffic, checked every cycle against a
// channel-level reference model of the arbiter.
module tb_dma_priority_arbiter;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic [3:0] DREQ;
  logic [7:0] commandReg;
  logic [3:0] maskReg;
  logic [3:0] requestReg;
  logic       idleCycle;
  logic       activeCycle;
  logic       validDack;
  logic       serviceDone;
  logic [3:0] VALID_DREQ;
  logic [1:0] grantCh;
  logic       grantValid;
  logic [3:0] DACK;
  logic [1:0] priorityPtr;

  int testsRun = 0;
  int testsFailed = 0;

  // Reference model: pin history, offer/lock flags and selected channel.
  logic [3:0] mS1, mS2;
  bit         mOffered, mLocked;
  int         mSel, mGrant, mPtr;

  dma_priority_arbiter #(.NCH(4)) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .DREQ        (DREQ),
    .commandReg  (commandReg),
    .maskReg     (maskReg),
    .requestReg  (requestReg),
    .idleCycle   (idleCycle),
    .activeCycle (activeCycle),
    .validDack   (validDack),
    .serviceDone (serviceDone),
    .VALID_DREQ  (VALID_DREQ),
    .grantCh     (grantCh),
    .grantValid  (grantValid),
    .DACK        (DACK),
    .priorityPtr (priorityPtr)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] dreq, input logic [7:0] cmd, input logic [3:0] mask,
                               input logic [3:0] req, input logic idle, input logic active,
                               input logic vdack, input logic sdone);
    DREQ        = dreq;
    commandReg  = cmd;
    maskReg     = mask;
    requestReg  = req;
    idleCycle   = idle;
    activeCycle = active;
    validDack   = vdack;
    serviceDone = sdone;
  endtask

  function automatic int scanWinner(input logic [3:0] pend, input int start);
    for (int k = 0; k < 4; k++) begin
      if (pend[(start + k) % 4]) return (start + k) % 4;
    end
    return 0;
  endfunction

  task automatic modelReset();
    mS1 = 4'h0; mS2 = 4'h0;
    mOffered = 1'b0; mLocked = 1'b0;
    mSel = 0; mGrant = 0; mPtr = 0;
  endtask

  task automatic modelUpdate();
    logic [3:0] sreq, pend;
    int startPtr;
    if (!RESET_N) begin
      modelReset();
      return;
    end
    sreq = mS2 ^ (commandReg[6] ? 4'hF : 4'h0);
    pend = (sreq & ~maskReg) | requestReg;
    startPtr = commandReg[4] ? mPtr : 0;
    if (mLocked) begin
      if (serviceDone) begin
        mLocked = 1'b0;
        if (commandReg[4]) mPtr = (mGrant + 1) % 4;
      end
    end else if (mOffered) begin
      if (activeCycle) begin
        mLocked = 1'b1; mOffered = 1'b0; mGrant = mSel;
      end else if (!pend[mSel] || commandReg[2]) begin
        mOffered = 1'b0;
      end
    end else if (idleCycle && !commandReg[2] && pend != 4'h0) begin
      mSel = scanWinner(pend, startPtr);
      mOffered = 1'b1;
    end
    if (!commandReg[4]) mPtr = 0;
    mS2 = mS1;
    mS1 = DREQ;
  endtask

  task automatic compareModel();
    logic [3:0] eValid, eDack;
    eValid = mOffered ? (4'b0001 << mSel) : (mLocked ? (4'b0001 << mGrant) : 4'b0000);
    eDack  = ((mLocked && validDack) ? (4'b0001 << mGrant) : 4'b0000) ^ (commandReg[7] ? 4'h0 : 4'hF);
    checkOutput("validDreq", 8'(VALID_DREQ), 8'(eValid));
    checkOutput("grantValid", 8'(grantValid), 8'(mLocked));
    checkOutput("grantCh", 8'(grantCh), 8'(mGrant));
    checkOutput("priorityPtr", 8'(priorityPtr), 8'(mPtr));
    checkOutput("dack", 8'(DACK), 8'(eDack));
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      modelUpdate();
      @(negedge CLK);
      compareModel();
    end
  endtask

  task automatic doReset();
    RESET_N = 1'b0;
    applyStimulus(4'h0, 8'h00, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    modelReset();
    tick(2);
    RESET_N = 1'b1;
  endtask

  task automatic asyncResetCheck(input logic [7:0] cmd);
    RESET_N = 1'b0;
    #1;
    checkOutput("rstValid", 8'(VALID_DREQ), 8'h00);
    checkOutput("rstGrantValid", 8'(grantValid), 8'h00);
    checkOutput("rstGrantCh", 8'(grantCh), 8'h00);
    checkOutput("rstPtr", 8'(priorityPtr), 8'h00);
    checkOutput("rstDack", 8'(DACK), cmd[7] ? 8'h00 : 8'h0F);
    modelReset();
    tick(1);
    RESET_N = 1'b1;
  endtask

  initial begin
    RESET_N = 1'b0;
    applyStimulus(4'h0, 8'h00, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    modelReset();
    @(negedge CLK);
    compareModel();
    checkOutput("resetDack", 8'(DACK), 8'h0F);
    tick(1);
    RESET_N = 1'b1;

    // Fixed priority grant and DACK polarity
    applyStimulus(4'b1010, 8'h00, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(3);
    checkOutput("fixedValid", 8'(VALID_DREQ), 8'h02);
    applyStimulus(4'b1010, 8'h00, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1);
    checkOutput("fixedGrantCh", 8'(grantCh), 8'h01);
    applyStimulus(4'b1010, 8'h00, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    checkOutput("fixedDack", 8'(DACK), 8'h0D);
    tick(1);
    applyStimulus(4'b1010, 8'h00, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1);
    checkOutput("fixedDone", 8'(grantValid), 8'h00);
    doReset();

    // Rotating priority pointer update
    applyStimulus(4'b0010, 8'h10, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(3);
    checkOutput("rotValid1", 8'(VALID_DREQ), 8'h02);
    applyStimulus(4'b0011, 8'h10, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1);
    applyStimulus(4'b0011, 8'h10, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(2);
    applyStimulus(4'b0011, 8'h10, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1);
    checkOutput("rotPtr", 8'(priorityPtr), 8'h02);
    applyStimulus(4'b0011, 8'h10, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1);
    checkOutput("rotValid2", 8'(VALID_DREQ), 8'h01);
    doReset();

    // Mask and software request
    applyStimulus(4'hF, 8'h00, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(3);
    checkOutput("maskedValid", 8'(VALID_DREQ), 8'h00);
    applyStimulus(4'hF, 8'h00, 4'hF, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1);
    checkOutput("swReqValid", 8'(VALID_DREQ), 8'h04);
    doReset();

    // Withdrawal before activeCycle, then coincident with activeCycle
    applyStimulus(4'b0100, 8'h00, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(3);
    checkOutput("wdOffer", 8'(VALID_DREQ), 8'h04);
    applyStimulus(4'b0000, 8'h00, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(2);
    checkOutput("wdHold", 8'(VALID_DREQ), 8'h04);
    tick(1);
    checkOutput("wdDrop", 8'(VALID_DREQ), 8'h00);
    checkOutput("wdNoGrant", 8'(grantValid), 8'h00);
    applyStimulus(4'b0100, 8'h00, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(3);
    applyStimulus(4'b0000, 8'h00, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(2);
    applyStimulus(4'b0000, 8'h00, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1);
    checkOutput("coinGrant", 8'(grantValid), 8'h01);
    checkOutput("coinGrantCh", 8'(grantCh), 8'h02);
    applyStimulus(4'b0000, 8'h00, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1);

    // Active-low DREQ, active-high DACK
    applyStimulus(4'b0111, 8'hC0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(3);
    applyStimulus(4'b0111, 8'hC0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1);
    checkOutput("polValid", 8'(VALID_DREQ), 8'h08);
    applyStimulus(4'b0111, 8'hC0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1);
    applyStimulus(4'b0111, 8'hC0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    checkOutput("polDackOn", 8'(DACK), 8'h08);
    applyStimulus(4'b0111, 8'hC0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("polDackOff", 8'(DACK), 8'h00);
    applyStimulus(4'b0111, 8'hC0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1);
    doReset();

    // Disable during grant: grant finishes, nothing new is offered
    applyStimulus(4'b0001, 8'h00, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(3);
    applyStimulus(4'b0001, 8'h00, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1);
    applyStimulus(4'b0001, 8'h04, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1);
    checkOutput("disHold", 8'(grantValid), 8'h01);
    applyStimulus(4'b0001, 8'h04, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1);
    checkOutput("disDone", 8'(grantValid), 8'h00);
    applyStimulus(4'b0001, 8'h04, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(4);
    checkOutput("disNoOffer", 8'(VALID_DREQ), 8'h00);

    // Asynchronous reset in the middle of a rotating-mode grant
    applyStimulus(4'b0100, 8'h10, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(3);
    applyStimulus(4'b0100, 8'h10, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1);
    applyStimulus(4'b0100, 8'h10, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    asyncResetCheck(8'h10);

    // Randomized traffic
    for (int cyc = 0; cyc < 1500; cyc++) begin
      logic [7:0] cmd;
      logic [3:0] dreq, mask, req;
      cmd = commandReg; dreq = DREQ; mask = maskReg; req = requestReg;
      if ($urandom_range(0, 49) == 0) begin
        cmd = 8'($urandom) & 8'hD0;
        if ($urandom_range(0, 7) == 0) cmd[2] = 1'b1;
        mask = 4'($urandom);
      end
      if ($urandom_range(0, 3) == 0) dreq = 4'($urandom);
      req = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      applyStimulus(dreq, cmd, mask, req, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 399) == 0) asyncResetCheck(cmd);
      else tick(1);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
